// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pkg
//  Description : Shared WS2812 timing constants, ns-to-cycles helper and the
//                receiver state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

   // Word width of one WS2812 colour word
   localparam int WS2812_WIDTH = 24;

   // Transmitter bit timing (ns)
   localparam int T1H_NS = 850;
   localparam int T0H_NS = 400;
   localparam int T1L_NS = 400;
   localparam int T0L_NS = 850;

   // Inter-frame reset gap (ns)
   localparam int TRESET_NS = 50000;

   // Receiver classification thresholds (ns)
   localparam int RX_THRESH_NS   = 600;
   localparam int RX_MIN_HIGH_NS = 100;
   localparam int RX_MAX_HIGH_NS = 2000;

   // Integer-only conversion: whole MHz first so large gaps do not overflow
   function automatic int ns_to_cyc(input int clk_fre, input int ns);
      return (clk_fre / 1_000_000) * ns / 1000;
   endfunction

   typedef enum logic [1:0] {
      ST_WAIT_RESET = 2'd0,
      ST_IDLE       = 2'd1,
      ST_HIGH       = 2'd2,
      ST_LOW        = 2'd3
   } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/ws2812_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_sync
//  Description : Two-flop synchronizer for an asynchronous single-wire input
//                with registered rise/fall strobes. level is aligned with the
//                strobes: a rise strobe is seen together with level==1.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   // Next values of the synchronizer chain and edge strobes
   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      prev_d = sync_q;
      rise_d = sync_q & ~prev_q;
      fall_d = ~sync_q & prev_q;
   end

   // Register the chain; reset clears every stage
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign level = prev_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/ws2812_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_rx
//  Description : WS2812 single-wire receiver. Classifies high pulses into
//                bits, assembles LSB-first 24-bit words, detects the reset
//                gap that ends a frame and latches one selected word.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int CLK_FRE     = 32_000_000,
   parameter int THRESH_NS   = RX_THRESH_NS,
   parameter int MIN_HIGH_NS = RX_MIN_HIGH_NS,
   parameter int MAX_HIGH_NS = RX_MAX_HIGH_NS,
   parameter int RESET_NS    = TRESET_NS,
   parameter int WORD_SEL    = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    din,
   output logic [WS2812_WIDTH-1:0] word_data,
   output logic                    word_valid,
   output logic [8:0]              word_idx,
   output logic [WS2812_WIDTH-1:0] color,
   output logic                    color_valid,
   output logic [8:0]              word_count,
   output logic                    frame_done,
   output logic                    err
);

   localparam int THRESH_CYC   = ns_to_cyc(CLK_FRE, THRESH_NS);
   localparam int MIN_HIGH_CYC = ns_to_cyc(CLK_FRE, MIN_HIGH_NS);
   localparam int MAX_HIGH_CYC = ns_to_cyc(CLK_FRE, MAX_HIGH_NS);
   localparam int RESET_CYC    = ns_to_cyc(CLK_FRE, RESET_NS);

   // Wide enough for both the reset gap and one count past the max high time
   localparam int CNT_W = $clog2(RESET_CYC + MAX_HIGH_CYC + 2);

   localparam logic [CNT_W-1:0] c_thresh    = CNT_W'(THRESH_CYC);
   localparam logic [CNT_W-1:0] c_min_high  = CNT_W'(MIN_HIGH_CYC);
   localparam logic [CNT_W-1:0] c_max_high  = CNT_W'(MAX_HIGH_CYC);
   localparam logic [CNT_W-1:0] c_reset_gap = CNT_W'(RESET_CYC);
   localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
   localparam logic [8:0]       c_word_sel  = 9'(WORD_SEL);
   localparam logic [8:0]       c_wcnt_max  = 9'h1FF;
   localparam logic [4:0]       c_last_bit  = 5'(WS2812_WIDTH - 1);

   logic w_level;
   logic w_rise;
   logic w_fall;
   logic w_bit;

   rx_state_e               state_q,       state_d;
   logic [CNT_W-1:0]        low_cnt_q,     low_cnt_d;
   logic [CNT_W-1:0]        high_cnt_q,    high_cnt_d;
   logic [4:0]              bit_idx_q,     bit_idx_d;
   logic [8:0]              wcnt_q,        wcnt_d;
   logic [WS2812_WIDTH-1:0] shreg_q,       shreg_d;
   logic [WS2812_WIDTH-1:0] word_data_q,   word_data_d;
   logic                    word_valid_q,  word_valid_d;
   logic [8:0]              word_idx_q,    word_idx_d;
   logic [WS2812_WIDTH-1:0] color_q,       color_d;
   logic                    color_valid_q, color_valid_d;
   logic [8:0]              word_count_q,  word_count_d;
   logic                    frame_done_q,  frame_done_d;
   logic                    err_q,         err_d;

   ws2812_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (din),
      .level (w_level),
      .rise  (w_rise),
      .fall  (w_fall)
   );

   // Receiver next-state logic: pulse classification, word assembly, framing
   always_comb begin
      state_d       = state_q;
      low_cnt_d     = low_cnt_q;
      high_cnt_d    = high_cnt_q;
      bit_idx_d     = bit_idx_q;
      wcnt_d        = wcnt_q;
      shreg_d       = shreg_q;
      word_data_d   = word_data_q;
      word_idx_d    = word_idx_q;
      color_d       = color_q;
      word_count_d  = word_count_q;
      word_valid_d  = 1'b0;
      color_valid_d = 1'b0;
      frame_done_d  = 1'b0;
      err_d         = 1'b0;
      w_bit         = (high_cnt_q >= c_thresh);

      case (state_q)
         // Wait for a full reset gap so we never lock on mid-frame
         ST_WAIT_RESET: begin
            if (w_level) begin
               low_cnt_d = '0;
            end else if (low_cnt_q != c_reset_gap) begin
               low_cnt_d = low_cnt_q + c_cnt_one;
            end
            if (low_cnt_d == c_reset_gap) begin
               state_d = ST_IDLE;
            end
         end

         ST_IDLE: begin
            if (w_rise) begin
               state_d    = ST_HIGH;
               high_cnt_d = c_cnt_one;
               bit_idx_d  = '0;
               wcnt_d     = '0;
            end
         end

         ST_HIGH: begin
            if (w_fall) begin
               if (high_cnt_q < c_min_high) begin
                  err_d     = 1'b1;
                  state_d   = ST_WAIT_RESET;
                  low_cnt_d = '0;
               end else begin
                  shreg_d[bit_idx_q] = w_bit;
                  state_d            = ST_LOW;
                  low_cnt_d          = c_cnt_one;
                  if (bit_idx_q == c_last_bit) begin
                     word_data_d  = shreg_d;
                     word_idx_d   = wcnt_q;
                     word_valid_d = 1'b1;
                     if (wcnt_q == c_word_sel) begin
                        color_d       = shreg_d;
                        color_valid_d = 1'b1;
                     end
                     if (wcnt_q != c_wcnt_max) begin
                        wcnt_d = wcnt_q + 9'd1;
                     end
                     bit_idx_d = '0;
                  end else begin
                     bit_idx_d = bit_idx_q + 5'd1;
                  end
               end
            end else if (high_cnt_q >= c_max_high) begin
               // The next high sample would exceed the maximum: line fault
               err_d     = 1'b1;
               state_d   = ST_WAIT_RESET;
               low_cnt_d = '0;
            end else begin
               high_cnt_d = high_cnt_q + c_cnt_one;
            end
         end

         ST_LOW: begin
            if (w_rise) begin
               state_d    = ST_HIGH;
               high_cnt_d = c_cnt_one;
            end else begin
               if (low_cnt_q != c_reset_gap) begin
                  low_cnt_d = low_cnt_q + c_cnt_one;
               end
               if (low_cnt_d == c_reset_gap) begin
                  // Frame ends; a partial word is dropped and flagged
                  word_count_d = wcnt_q;
                  frame_done_d = 1'b1;
                  err_d        = (bit_idx_q != 5'd0);
                  state_d      = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_WAIT_RESET;
         end
      endcase
   end

   // Receiver state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_WAIT_RESET;
         low_cnt_q     <= '0;
         high_cnt_q    <= '0;
         bit_idx_q     <= '0;
         wcnt_q        <= '0;
         shreg_q       <= '0;
         word_data_q   <= '0;
         word_valid_q  <= 1'b0;
         word_idx_q    <= '0;
         color_q       <= '0;
         color_valid_q <= 1'b0;
         word_count_q  <= '0;
         frame_done_q  <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         low_cnt_q     <= low_cnt_d;
         high_cnt_q    <= high_cnt_d;
         bit_idx_q     <= bit_idx_d;
         wcnt_q        <= wcnt_d;
         shreg_q       <= shreg_d;
         word_data_q   <= word_data_d;
         word_valid_q  <= word_valid_d;
         word_idx_q    <= word_idx_d;
         color_q       <= color_d;
         color_valid_q <= color_valid_d;
         word_count_q  <= word_count_d;
         frame_done_q  <= frame_done_d;
         err_q         <= err_d;
      end
   end

   assign word_data   = word_data_q;
   assign word_valid  = word_valid_q;
   assign word_idx    = word_idx_q;
   assign color       = color_q;
   assign color_valid = color_valid_q;
   assign word_count  = word_count_q;
   assign frame_done  = frame_done_q;
   assign err         = err_q;

endmodule
`default_nettype wire

// File: doc/ws2812_rx.md
# ws2812_rx

Single-wire WS2812 protocol receiver and decoder, the counterpart of the team's WS2812 transmitter. It samples an asynchronous data line, classifies each high pulse as a 0 or 1 bit, and assembles 24-bit words. It detects the inter-frame reset gap and captures one selected word per frame as a colour. It serves as a loopback checker for the LED driver path and as an input port for daisy-chained WS2812 streams.

## Interface

Parameters:
- CLK_FRE, 32_000_000: clk frequency in Hz.
- THRESH_NS, 600: high-pulse width at or above which a bit decodes as 1.
- MIN_HIGH_NS, 100: shorter high pulses are glitches.
- MAX_HIGH_NS, 2000: longer high pulses are line faults.
- RESET_NS, 50000: low time that ends a frame.
- WORD_SEL, 0: word index within a frame latched onto color.

Derived cycle counts use integer math only: X_CYC = CLK_FRE/1_000_000 * X_NS / 1000. At the defaults these are THRESH 19, MIN_HIGH 3, MAX_HIGH 64, RESET 1600.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- din, input, 1: asynchronous WS2812 line.
- word_data, output, 24: last completed word.
- word_valid, output, 1: one-cycle pulse when word_data updates.
- word_idx, output, 9: index of word_data within the current frame.
- color, output, 24: latched word number WORD_SEL.
- color_valid, output, 1: one-cycle pulse when color updates.
- word_count, output, 9: number of complete words in the last finished frame.
- frame_done, output, 1: one-cycle pulse at frame end.
- err, output, 1: one-cycle pulse on a protocol error.

## Operation

- din passes through a 2-flop synchronizer and a third flop for edge detection. Rise and fall are single-cycle strobes.
- Bit order: the first bit on the wire lands in bit 0, so words are sent LSB first.
- States:
  - WAIT_RESET (entered on reset): low_cnt counts while din is low and clears whenever din is high. When low_cnt reaches RESET_CYC, go to IDLE. This prevents locking onto a stream mid-frame.
  - IDLE: a rise goes to HIGH with high_cnt=1, bit_idx=0, wcnt=0.
  - HIGH: high_cnt increments while din is high.
    - If high_cnt exceeds MAX_HIGH_CYC: err pulse, go to WAIT_RESET.
    - On a fall with high_cnt < MIN_HIGH_CYC: err pulse, go to WAIT_RESET.
    - On any other fall: shreg[bit_idx] = (high_cnt >= THRESH_CYC), then go to LOW with low_cnt=1.
    - If that bit was the 24th (bit_idx==23): word_data=shreg, word_idx=wcnt, word_valid pulse. If wcnt==WORD_SEL, also color and color_valid. Then wcnt++ (saturating at 511) and bit_idx=0. Otherwise bit_idx++.
  - LOW: a rise goes to HIGH with high_cnt=1. If low_cnt reaches RESET_CYC: word_count=wcnt, frame_done pulse, go to IDLE.
    - If bit_idx!=0 at that point (partial word), err pulses in the same cycle as frame_done. The partial bits are discarded and do not count toward word_count.
- Counters are sized to hold RESET_CYC and saturate; they never wrap.
- Low time between bits is not checked against a minimum. Any low time shorter than RESET_CYC is intra-frame.

## Timing

- Reset values:
  - Outputs: word_data=0, word_idx=0, color=0, word_count=0; all pulse outputs 0.
  - State WAIT_RESET; synchronizer flops 0.
- Reset dominates every other event, including mid-word or mid-frame. Partial data is dropped with no err and no frame_done.
- Latency: word_valid/color_valid assert on the 4th rising clk edge after din falls at the end of bit 23 (2 synchronizer stages, edge flop, output register). frame_done asserts RESET_CYC+3 edges after the last fall.
- Decode accuracy: the measured high width has ±1 cycle of synchronizer jitter. THRESH_CYC-1 samples decode as 0; THRESH_CYC samples decode as 1.
- The word_valid and frame_done pulses never coincide. A word always completes at a fall, and a frame always ends at least RESET_CYC later.

## Structure

- Shared package ws2812_pkg:
  - Nanosecond timing constants: the transmitter's 1-high/0-high/1-low/0-low times, the reset gap, and the receiver threshold values.
  - The ns-to-cycles constant function.
  - The WS2812_WIDTH=24 constant.
  - The receiver state enum (WAIT_RESET, IDLE, HIGH, LOW).
- One sub-module, ws2812_sync: 2-flop synchronizer plus edge detector. Outputs are the synchronized level, rise, and fall. It is reusable for other asynchronous single-wire inputs.

## Test plan

- Single word: after reset, hold din low 60 us, then drive 0xA5C3F0 LSB first (1 = 850/400 ns, 0 = 400/850 ns). Required: one word_valid with word_data=0xA5C3F0, word_idx=0; color=0xA5C3F0 with color_valid. After 50 us low: frame_done, word_count=1, no err.
- Three words, WORD_SEL=1: send 0x000001, 0x800000, 0x123456. Required: word_valid ×3 with idx 0,1,2; color=0x800000 and a single color_valid; word_count=3.
- Threshold and glitch:
  - High of exactly 19 cycles decodes as 1; 18 cycles decodes as 0.
  - A 1-cycle high pulse gives err and a return to WAIT_RESET; the next frame decodes after a 50 us low.
- Stuck high: din high for 3 us mid-word. Required: err at cycle 65 of high, no word_valid, no frame_done; recovery after the reset gap.
- Partial word: send 10 bits, then 50 us low. Required: frame_done and err in the same cycle, word_count=0, word_data unchanged.
- Reset mid-frame:
  - Assert reset during bit 12. Required: all outputs return to reset values.
  - Release reset with the stream still running. Required: no decode until a 50 us low gap has been seen, then normal decode.
